// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state, line-state flags and address-field helpers for cache_nway_wb.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  typedef struct packed {
    logic valid;
    logic dirty;
  } line_state_t;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int off_w(int words);
    return 2 + $clog2(words);
  endfunction
  function automatic int tag_w(int addr_w, int sets, int words);
    return addr_w - off_w(words) - $clog2(sets);
  endfunction
  function automatic int set_of(logic [31:0] addr, int sets, int words);
    return int'((addr >> off_w(words)) & 32'(sets - 1));
  endfunction
  function automatic int word_of(logic [31:0] addr, int words);
    return int'((addr >> 2) & 32'(words - 1));
  endfunction
  function automatic logic [31:0] tag_of(logic [31:0] addr, int sets, int words);
    return addr >> (off_w(words) + $clog2(sets));
  endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU ages (0 = MRU) with victim selection preferring the lowest invalid way.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 2,
  localparam int AW = idx_w(WAYS),
  localparam int SI_W = idx_w(SETS)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [SI_W-1:0] set_i,
  input  logic [WAYS-1:0] valid_i,
  input  logic            upd_i,
  input  logic [AW-1:0]   way_i,
  output logic [AW-1:0]   victim_o
);
  logic [AW-1:0] age_q [SETS][WAYS];
  always_comb begin
    victim_o = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[set_i][w] == AW'(WAYS - 1)) victim_o = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) victim_o = AW'(w);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AW'(w);
    end else if (upd_i) begin
      for (int w = 0; w < WAYS; w++)
        age_q[set_i][w] <= (AW'(w) == way_i) ? '0 :
                           (age_q[set_i][w] < age_q[set_i][way_i]) ? age_q[set_i][w] + 1'b1 :
                           age_q[set_i][w];
    end
endmodule

// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back cache controller with true-LRU replacement.
// Define CACHE_WRITE_THROUGH_EN for write-through, no-write-allocate operation.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 2,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_write,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    hit,
  output logic                    mem_req,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W*WORDS-1:0] mem_wdata,
  input  logic [DATA_W*WORDS-1:0] mem_rdata,
  input  logic                    mem_ready
);
`ifdef CACHE_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif
  localparam int OFF_W  = off_w(WORDS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, WORDS);
  localparam int LO_W   = ADDR_W - TAG_W;
  localparam int WI_W   = idx_w(WAYS);
  localparam int SI_W   = idx_w(SETS);
  localparam int LINE_W = DATA_W * WORDS;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W-1:0] SET_MASK = ADDR_W'(SETS - 1) << OFF_W;
  typedef struct packed {
    line_state_t         st;
    logic [TAG_W-1:0]    tag;
    logic [LINE_W-1:0]   data;
  } line_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              miss_q, miss_d;
  logic [WI_W-1:0]   victim_q, victim_d, hit_way, lru_victim;
  line_t             line_q [SETS][WAYS];
  logic [SI_W-1:0]   set_idx;
  logic [TAG_W-1:0]  tag_r;
  int                word_i;
  logic [WAYS-1:0]   hit_vec, valid_vec;
  logic              is_hit;
  logic [LINE_W-1:0] merged;
  logic [DATA_W-1:0] hit_word;
  logic [ADDR_W-1:0] blk_addr;
  line_t             cand, vic;
  assign set_idx  = SI_W'(set_of(32'(addr_q), SETS, WORDS));
  assign tag_r    = TAG_W'(tag_of(32'(addr_q), SETS, WORDS));
  assign word_i   = word_of(32'(addr_q), WORDS);
  assign blk_addr = addr_q & ~OFF_MASK;
  assign cand     = line_q[set_idx][lru_victim];
  assign vic      = line_q[set_idx][victim_q];
  assign is_hit   = |hit_vec;
  assign hit      = cpu_ready && !miss_q;
  always_comb begin
    hit_vec = '0;
    valid_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = line_q[set_idx][w].st.valid;
      hit_vec[w] = valid_vec[w] && (line_q[set_idx][w].tag == tag_r);
      if (hit_vec[w]) hit_way = WI_W'(w);
    end
  end
  // Word 0 lives in the MSBs; a miss merges into zeros (write-through store miss only).
  always_comb begin
    merged = is_hit ? line_q[set_idx][hit_way].data : '0;
    hit_word = merged[(WORDS - 1 - word_i) * DATA_W +: DATA_W];
    merged[(WORDS - 1 - word_i) * DATA_W +: DATA_W] = wdata_q;
  end
  cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk      (clk),
    .rst      (rst),
    .set_i    (set_idx),
    .valid_i  (valid_vec),
    .upd_i    (state_q == COMPARE && is_hit),
    .way_i    (hit_way),
    .victim_o (lru_victim)
  );
  always_comb begin
    state_d = state_q;
    miss_d = miss_q;
    victim_d = victim_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        state_d = cpu_req ? COMPARE : IDLE;
        miss_d = cpu_req ? 1'b0 : miss_q;
      end
      COMPARE:
        if (WT && write_q) begin
          state_d = ALLOCATE;
          miss_d = !is_hit;
        end else if (is_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = write_q ? '0 : hit_word;
          state_d = IDLE;
        end else begin
          victim_d = lru_victim;
          miss_d = 1'b1;
          state_d = (cand.st.valid && cand.st.dirty) ? WRITEBACK : ALLOCATE;
        end
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        mem_addr = {vic.tag, LO_W'(0)} | (addr_q & SET_MASK);
        mem_wdata = vic.data;
        state_d = mem_ready ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        mem_req = 1'b1;
        mem_addr = blk_addr;
        mem_write = WT && write_q;
        mem_wdata = mem_write ? merged : '0;
        cpu_ready = mem_write && mem_ready;
        state_d = mem_ready ? (mem_write ? IDLE : COMPARE) : ALLOCATE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      miss_q <= 1'b0;
      victim_q <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          line_q[s][w] <= '0;
    end else begin
      state_q <= state_d;
      miss_q <= miss_d;
      victim_q <= victim_d;
      if (state_q == IDLE && cpu_req) begin
        addr_q <= cpu_addr;
        write_q <= cpu_write;
        wdata_q <= cpu_wdata;
      end
      if (state_q == COMPARE && is_hit && write_q) begin
        line_q[set_idx][hit_way].data <= merged;
        line_q[set_idx][hit_way].st.dirty <= !WT;
      end
      if (state_q == WRITEBACK && mem_ready)
        line_q[set_idx][victim_q].st.dirty <= 1'b0;
      if (state_q == ALLOCATE && mem_ready && !mem_write)
        line_q[set_idx][victim_q] <= {1'b1, 1'b0, tag_r, mem_rdata};
    end
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb_cache_nway_wb: directed bench for cache_nway_wb with a block-memory responder and configurable stall.
module tb_cache_nway_wb;
  logic         clk = 1'b0;
  logic         rst, cpu_req, cpu_write;
  logic [9:0]   cpu_addr, mem_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, hit, mem_req, mem_write;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  int checks = 0, errors = 0;
  int stall = 0, wait_cnt = 0, fill_cnt = 0, wb_cnt = 0;
  logic [9:0]   last_fill_addr = '0, last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;
  logic [127:0] mem_m [64];
  logic [63:0]  mem_wr = '0;

  cache_nway_wb dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wv(int b, int k);
    return 32'hA000_0000 + 32'(b * 16 + k);
  endfunction
  function automatic logic [127:0] blk(int b);
    return {wv(b, 0), wv(b, 1), wv(b, 2), wv(b, 3)};
  endfunction

  // Memory responder: acknowledges after 'stall' waiting cycles, drives on the falling edge.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (rst || !mem_req) wait_cnt = 0;
    else if (wait_cnt < stall) wait_cnt++;
    else begin
      wait_cnt = 0;
      mem_ready = 1'b1;
      if (mem_write) begin
        mem_m[mem_addr[9:4]] = mem_wdata;
        mem_wr[mem_addr[9:4]] = 1'b1;
        wb_cnt++;
        last_wb_addr = mem_addr;
        last_wb_data = mem_wdata;
      end else begin
        mem_rdata = mem_wr[mem_addr[9:4]] ? mem_m[mem_addr[9:4]] : blk(int'(mem_addr[9:4]));
        fill_cnt++;
        last_fill_addr = mem_addr;
      end
    end
  end

  task automatic access(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic h, output int lat);
    logic got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    lat = 1; rd = '0; h = 1'b0; got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ready) begin
        got = 1'b1; rd = cpu_rdata; h = hit;
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL access_timeout addr=%h got no cpu_ready, required one", a); end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got %b exp 0", cpu_ready); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", hit); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 0", cpu_rdata); end
    checks++; if (mem_addr !== 10'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd; logic h; int lat, f0;
    f0 = fill_cnt;
    access(1'b0, 10'h010, 32'h0, rd, h, lat);
    checks++; if (rd !== wv(1, 0)) begin errors++; $display("FAIL cold_rdata got %h exp %h", rd, wv(1, 0)); end
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL cold_hit got %b exp 0", h); end
    checks++; if (fill_cnt != f0 + 1 || last_fill_addr !== 10'h010) begin errors++; $display("FAIL cold_fill got cnt=%0d addr=%h exp cnt=%0d addr=010", fill_cnt, last_fill_addr, f0 + 1); end
    f0 = fill_cnt;
    access(1'b0, 10'h014, 32'h0, rd, h, lat);
    checks++; if (rd !== wv(1, 1)) begin errors++; $display("FAIL reload_rdata got %h exp %h", rd, wv(1, 1)); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL reload_hit got %b exp 1", h); end
    checks++; if (lat != 2) begin errors++; $display("FAIL hit_latency got %0d exp 2", lat); end
    checks++; if (fill_cnt != f0 || wb_cnt != 0) begin errors++; $display("FAIL reload_no_mem got fills=%0d wbs=%0d exp fills=%0d wbs=0", fill_cnt, wb_cnt, f0); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; logic h; int lat, f0;
    f0 = fill_cnt;
    access(1'b1, 10'h018, 32'hDEADBEEF, rd, h, lat);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL store_hit got %b exp 1", h); end
    checks++; if (fill_cnt != f0 || wb_cnt != 0) begin errors++; $display("FAIL store_no_mem got fills=%0d wbs=%0d exp fills=%0d wbs=0", fill_cnt, wb_cnt, f0); end
    access(1'b0, 10'h018, 32'h0, rd, h, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_readback got %h exp deadbeef", rd); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL store_readback_hit got %b exp 1", h); end
  endtask

  task automatic test_lru();
    logic [31:0] rd; logic h; int lat;
    access(1'b0, 10'h010, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL lru_a_hit got %b exp 1", h); end
    access(1'b0, 10'h030, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b0 || rd !== wv(3, 0)) begin errors++; $display("FAIL lru_b_miss got hit=%b rd=%h exp hit=0 rd=%h", h, rd, wv(3, 0)); end
    access(1'b0, 10'h010, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL lru_a2_hit got %b exp 1", h); end
    access(1'b0, 10'h050, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b0 || rd !== wv(5, 0) || last_fill_addr !== 10'h050) begin errors++; $display("FAIL lru_c_miss got hit=%b rd=%h fill=%h exp hit=0 rd=%h fill=050", h, rd, last_fill_addr, wv(5, 0)); end
    checks++; if (wb_cnt != 0) begin errors++; $display("FAIL lru_clean_victim got wbs=%0d exp 0", wb_cnt); end
    access(1'b0, 10'h010, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b1 || rd !== wv(1, 0)) begin errors++; $display("FAIL lru_a3_hit got hit=%b rd=%h exp hit=1 rd=%h", h, rd, wv(1, 0)); end
    access(1'b0, 10'h030, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL lru_b_evicted got hit=%b exp 0", h); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd; logic h; int lat, w0;
    w0 = wb_cnt;
    access(1'b1, 10'h010, 32'h12345678, rd, h, lat);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL dirty_store_hit got %b exp 1", h); end
    access(1'b0, 10'h030, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL dirty_b_hit got %b exp 1", h); end
    access(1'b0, 10'h050, 32'h0, rd, h, lat);
    checks++; if (wb_cnt != w0 + 1 || last_wb_addr !== 10'h010) begin errors++; $display("FAIL wb_addr got cnt=%0d addr=%h exp cnt=%0d addr=010", wb_cnt, last_wb_addr, w0 + 1); end
    checks++; if (last_wb_data[127:96] !== 32'h12345678) begin errors++; $display("FAIL wb_word0 got %h exp 12345678", last_wb_data[127:96]); end
    checks++; if (last_wb_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_word2 got %h exp deadbeef", last_wb_data[63:32]); end
    checks++; if (last_fill_addr !== 10'h050 || rd !== wv(5, 0) || h !== 1'b0) begin errors++; $display("FAIL wb_then_fill got fill=%h rd=%h hit=%b exp fill=050 rd=%h hit=0", last_fill_addr, rd, h, wv(5, 0)); end
    access(1'b0, 10'h010, 32'h0, rd, h, lat);
    checks++; if (rd !== 32'h12345678 || h !== 1'b0) begin errors++; $display("FAIL wb_refetch got rd=%h hit=%b exp rd=12345678 hit=0", rd, h); end
  endtask

  task automatic test_stall();
    int n;
    stall = 5;
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h070; cpu_wdata = '0;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h070) begin errors++; $display("FAIL stall_start got req=%b addr=%h exp req=1 addr=070", mem_req, mem_addr); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 10'h070 || mem_write !== 1'b0 || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got req=%b addr=%h wr=%b rdy=%b exp 1 070 0 0", i, mem_req, mem_addr, mem_write, cpu_ready);
      end
    end
    n = 0;
    while (!cpu_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== wv(7, 0) || hit !== 1'b0) begin errors++; $display("FAIL stall_done got rdy=%b rd=%h hit=%b exp 1 %h 0", cpu_ready, cpu_rdata, hit, wv(7, 0)); end
    @(negedge clk);
    cpu_req = 1'b0;
    stall = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic h; int lat, n, f0;
    stall = 50;
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h090; cpu_wdata = '0;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b exp 1", mem_req); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 10'h0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_drop got req=%b addr=%h rdy=%b exp 0 000 0", mem_req, mem_addr, cpu_ready); end
    @(negedge clk);
    cpu_req = 1'b0;
    stall = 0;
    @(negedge clk);
    rst = 1'b0;
    f0 = fill_cnt;
    access(1'b0, 10'h010, 32'h0, rd, h, lat);
    checks++; if (h !== 1'b0 || fill_cnt != f0 + 1) begin errors++; $display("FAIL rstmid_miss got hit=%b fills=%0d exp hit=0 fills=%0d", h, fill_cnt, f0 + 1); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rstmid_rdata got %h exp 12345678", rd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_cold_miss();
    test_store_hit();
    test_lru();
    test_dirty_evict();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
